count15_timer_ctrl: RTL and testbench

//  Sequencer for one external 15-bit up/down loadable counter (LD/Din/Up/Dw in; Q/UTC/DTC out).

---
 rtl/count15_timer_ctrl.sv | 116 +++++++++++
 tb/tb_count15_timer_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count15_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : count15_timer_ctrl
// Brief   : Sequencer for an external loadable up/down counter: load, tick-
//           gated counting, terminal detection, pause/abort, optional reload.
// Revision: 1.0 - initial release
// ============================================================================
module count15_timer_ctrl #(
    parameter int WIDTH       = 15,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir_up,
    input  logic [WIDTH-1:0] limit,
    input  logic             tick,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             cnt_ld,
    output logic [WIDTH-1:0] cnt_din,
    output logic             cnt_up,
    output logic             cnt_dw,
    input  logic [WIDTH-1:0] cnt_q,
    input  logic             cnt_utc,
    input  logic             cnt_dtc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             w_latch;
    logic [WIDTH-1:0] r_lim;
    logic             r_dir;
    logic             w_term;
    logic             w_cnt_en;
    logic             w_unused;

    // UTC is informational only; the up terminal is the Q==limit compare
    assign w_unused = cnt_utc;

    assign w_term = r_dir ? (cnt_q == r_lim) : cnt_dtc;

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_next  = S_LOAD;
                    w_latch = 1'b1;
                end
            end
            S_LOAD: begin
                w_next = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort)       w_next = S_IDLE;
                else if (w_term) w_next = S_DONE;
                else if (pause)  w_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (abort)       w_next = S_IDLE;
                else if (!pause) w_next = S_RUN;
            end
            S_DONE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (start) begin
                    w_next  = S_LOAD;
                    w_latch = 1'b1;
                end else if (AUTO_RELOAD != 0) begin
                    w_next = S_LOAD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_lim   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_lim <= limit;
                r_dir <= dir_up;
            end
        end
    end

    assign busy    = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_PAUSE);
    assign paused  = (r_state == S_PAUSE);
    assign done    = (r_state == S_DONE);
    assign cnt_ld  = (r_state == S_LOAD);
    assign cnt_din = (r_state == S_LOAD && !r_dir) ? r_lim : '0;

    // Count strobes only in RUN, and never once the terminal is already reached
    assign w_cnt_en = (r_state == S_RUN) && tick && !w_term && !pause && !abort;
    assign cnt_up   = w_cnt_en &&  r_dir;
    assign cnt_dw   = w_cnt_en && !r_dir;

endmodule
`default_nettype wire

// File: tb/tb_count15_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_count15_timer_ctrl
// Brief   : Directed self-checking bench with a behavioural 15-bit counter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_count15_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, dir_up = 1'b0, tick = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [14:0] limit = 15'd0;
    logic        busy, paused, done, cnt_ld, cnt_up, cnt_dw;
    logic [14:0] cnt_din;
    logic [14:0] q = 15'h1234;
    logic        utc, dtc;

    logic        b_start = 1'b0, b_abort = 1'b0;
    logic        b_busy, b_paused, b_done, b_ld, b_up, b_dw;
    logic [14:0] b_din;
    logic [14:0] b_q = 15'h0abc;
    logic        b_utc, b_dtc;

    int tests = 0, fails = 0;
    int n_up = 0, n_dw = 0, n_done = 0;
    int d0, dn0, u0;

    always #5 clk = ~clk;

    count15_timer_ctrl #(.WIDTH(15), .AUTO_RELOAD(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir_up(dir_up), .limit(limit),
        .tick(tick), .pause(pause), .abort(abort), .busy(busy), .paused(paused),
        .done(done), .cnt_ld(cnt_ld), .cnt_din(cnt_din), .cnt_up(cnt_up),
        .cnt_dw(cnt_dw), .cnt_q(q), .cnt_utc(utc), .cnt_dtc(dtc)
    );

    count15_timer_ctrl #(.WIDTH(15), .AUTO_RELOAD(1)) u_dut_ar (
        .clk(clk), .rst_n(rst_n), .start(b_start), .dir_up(dir_up), .limit(limit),
        .tick(tick), .pause(pause), .abort(b_abort), .busy(b_busy), .paused(b_paused),
        .done(b_done), .cnt_ld(b_ld), .cnt_din(b_din), .cnt_up(b_up),
        .cnt_dw(b_dw), .cnt_q(b_q), .cnt_utc(b_utc), .cnt_dtc(b_dtc)
    );

    // External counters: no reset, load has priority
    always @(posedge clk) begin
        if (cnt_ld)      q <= cnt_din;
        else if (cnt_up) q <= q + 15'd1;
        else if (cnt_dw) q <= q - 15'd1;
        if (b_ld)        b_q <= b_din;
        else if (b_up)   b_q <= b_q + 15'd1;
        else if (b_dw)   b_q <= b_q - 15'd1;
    end
    assign utc   = (q == 15'h7fff);
    assign dtc   = (q == 15'd0);
    assign b_utc = (b_q == 15'h7fff);
    assign b_dtc = (b_q == 15'd0);

    always @(posedge clk) begin
        if (cnt_up) n_up <= n_up + 1;
        if (cnt_dw) n_dw <= n_dw + 1;
        if (done)   n_done <= n_done + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // n single-cycle ticks, one idle cycle between; returns in the cycle after the last tick edge
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (i != n - 1) cyc();
        end
    endtask

    task automatic go(input logic up, input logic [14:0] lim);
        dir_up = up;
        limit  = lim;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", 32'({paused, done, cnt_ld, cnt_up, cnt_dw}), 32'd0);
        chk("rst_din", 32'(cnt_din), 32'd0);
        rst_n = 1'b1;
        cyc();

        // 1: reset mid-RUN
        go(1'b0, 15'd9);
        cyc();
        ticks(1);
        chk("t1_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_outs", 32'({paused, done, cnt_ld, cnt_up, cnt_dw}), 32'd0);
        dn0 = n_done;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t1_no_done", 32'(n_done - dn0), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: down from 5, ticks spaced 3 cycles
        go(1'b0, 15'd5);
        chk("t2_ld", 32'(cnt_ld), 32'd1);
        chk("t2_din", 32'(cnt_din), 32'd5);
        cyc();
        chk("t2_q5", 32'(q), 32'd5);
        d0 = n_dw; dn0 = n_done;
        for (int i = 1; i <= 5; i++) begin
            tick = 1'b1;
            #1;
            chk("t2_dw", 32'(cnt_dw), 32'd1);
            cyc();
            tick = 1'b0;
            chk("t2_q", 32'(q), 32'(5 - i));
            if (i < 5) begin cyc(); cyc(); end
        end
        tick = 1'b1;
        #1;
        chk("t2_term_nodw", 32'(cnt_dw), 32'd0);
        chk("t2_term_nodone", 32'(done), 32'd0);
        cyc();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_done_nodw", 32'(cnt_dw), 32'd0);
        tick = 1'b0;
        cyc();
        chk("t2_done_once", 32'(done), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_ndw", 32'(n_dw - d0), 32'd5);
        chk("t2_ndone", 32'(n_done - dn0), 32'd1);
        chk("t2_qfinal", 32'(q), 32'd0);

        // 3: up to 3 with 6 back-to-back ticks
        go(1'b1, 15'd3);
        chk("t3_ld", 32'(cnt_ld), 32'd1);
        chk("t3_din", 32'(cnt_din), 32'd0);
        cyc();
        chk("t3_q0", 32'(q), 32'd0);
        u0 = n_up; dn0 = n_done;
        tick = 1'b1;
        repeat (6) cyc();
        tick = 1'b0;
        chk("t3_nup", 32'(n_up - u0), 32'd3);
        chk("t3_q3", 32'(q), 32'd3);
        chk("t3_ndone", 32'(n_done - dn0), 32'd1);
        chk("t3_idle", 32'(busy), 32'd0);

        // abort + start together in IDLE
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("abst_busy", 32'(busy), 32'd0);
        chk("abst_ld", 32'(cnt_ld), 32'd0);

        // 4: down, limit 0, no ticks
        go(1'b0, 15'd0);
        chk("t4_ld_k1", 32'(cnt_ld), 32'd1);
        cyc();
        chk("t4_k2", 32'({busy, done, cnt_ld}), 32'b100);
        cyc();
        chk("t4_done_k3", 32'(done), 32'd1);
        cyc();

        // 5: pause holds the count
        go(1'b0, 15'd10);
        cyc();
        d0 = n_dw;
        ticks(2);
        chk("t5_q8", 32'(q), 32'd8);
        pause = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) begin
            tick = (i % 2 == 0);
            #1;
            chk("t5_nodw", 32'(cnt_dw), 32'd0);
            cyc();
            tick = 1'b0;
            chk("t5_hold", 32'(q), 32'd8);
            chk("t5_paused", 32'(paused), 32'd1);
        end
        pause = 1'b0;
        cyc();
        chk("t5_resume", 32'({busy, paused}), 32'b10);
        ticks(8);
        chk("t5_q0", 32'(q), 32'd0);
        cyc();
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_ndw", 32'(n_dw - d0), 32'd10);
        cyc();

        // 6: abort mid-run
        go(1'b0, 15'd100);
        cyc();
        ticks(3);
        chk("t6_q97", 32'(q), 32'd97);
        dn0 = n_done;
        abort = 1'b1; tick = 1'b1;
        #1;
        chk("t6_nodw", 32'(cnt_dw), 32'd0);
        cyc();
        abort = 1'b0; tick = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        cyc(); cyc();
        chk("t6_frozen", 32'(q), 32'd97);
        chk("t6_nodone", 32'(n_done - dn0), 32'd0);

        // 7: start while busy is ignored
        go(1'b1, 15'd7);
        cyc();
        u0 = n_up; dn0 = n_done;
        ticks(2);
        dir_up = 1'b0; limit = 15'd2; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("t7_still_busy", 32'(busy), 32'd1);
        chk("t7_q2", 32'(q), 32'd2);
        chk("t7_nodone", 32'(n_done - dn0), 32'd0);
        ticks(5);
        chk("t7_q7", 32'(q), 32'd7);
        chk("t7_term_nodone", 32'(done), 32'd0);
        cyc();
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_nup", 32'(n_up - u0), 32'd7);
        cyc();

        // 8: auto-reload instance
        dir_up = 1'b0; limit = 15'd2; b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        chk("t8_ld", 32'(b_ld), 32'd1);
        chk("t8_din", 32'(b_din), 32'd2);
        cyc();
        for (int r = 0; r < 2; r++) begin
            chk("t8_q2", 32'(b_q), 32'd2);
            ticks(2);
            chk("t8_q0", 32'(b_q), 32'd0);
            cyc();
            chk("t8_done", 32'(b_done), 32'd1);
            cyc();
            chk("t8_reld", 32'({b_ld, b_done}), 32'b10);
            chk("t8_redin", 32'(b_din), 32'd2);
            cyc();
        end
        b_abort = 1'b1;
        cyc();
        b_abort = 1'b0;
        chk("t8_abort", 32'(b_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
